// File: rtl/host_ctrl_pkg.sv
// rtl/host_ctrl_pkg.sv - shared command codes, FSM states, read-map addresses and flag indices
package host_ctrl_pkg;

  localparam logic [3:0] CMD_NOP     = 4'h0;
  localparam logic [3:0] CMD_READ    = 4'h1;
  localparam logic [3:0] CMD_TX_PUSH = 4'h2;
  localparam logic [3:0] CMD_INT_CLR = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_CNT_LO  = 4'd8;
  localparam logic [3:0] ADDR_CNT_HI  = 4'd9;
  localparam logic [3:0] ADDR_FRAMES  = 4'd10;
  localparam logic [3:0] ADDR_STATUS  = 4'd11;
  localparam logic [3:0] ADDR_FLAGS   = 4'd12;
  localparam logic [3:0] ADDR_INT     = 4'd13;
  localparam logic [3:0] ADDR_VERSION = 4'd14;

  localparam int FLAG_OVF    = 0;
  localparam int FLAG_BADCMD = 1;
  localparam int FLAG_FRAME  = 2;
  localparam int FLAG_EMPTY  = 3;

  localparam logic [7:0] ILLEGAL_ACK = 8'hEE;

endpackage

// File: rtl/sync_toggle_det.sv
// rtl/sync_toggle_det.sv - host toggle detector; HOST_SYNC_2FF_EN adds a 2-flop stage on sync/cmd/data
module sync_toggle_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ready,
  input  logic       sync,
  input  logic [3:0] cmd,
  input  logic [7:0] data,
  output logic       new_cmd,
  output logic [3:0] cmd_q,
  output logic [7:0] data_q,
  output logic       seen
);

  logic       sync_s;
  logic [3:0] cmd_s;
  logic [7:0] data_s;

`ifdef HOST_SYNC_2FF_EN
  logic [12:0] stage1;
  logic [12:0] stage2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= {sync, cmd, data};
      stage2 <= stage1;
    end
  end

  assign {sync_s, cmd_s, data_s} = stage2;
`else
  assign {sync_s, cmd_s, data_s} = {sync, cmd, data};
`endif

  // Level compare against the last accepted toggle, so toggles seen while busy are not lost
  assign new_cmd = en && ready && (sync_s != seen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen   <= 1'b0;
      cmd_q  <= '0;
      data_q <= '0;
    end else if (!en) begin
      seen <= 1'b0;
    end else if (new_cmd) begin
      seen   <= sync_s;
      cmd_q  <= cmd_s;
      data_q <= data_s;
    end
  end

endmodule

// File: rtl/host_cmd_ctrl.sv
// rtl/host_cmd_ctrl.sv - host command sequencer: register bank, TX push, read map, flags and interrupt
// Optional asynchronous-host input stage selected by HOST_SYNC_2FF_EN (see sync_toggle_det).
module host_cmd_ctrl #(
  parameter int unsigned TX_DEPTH = 1024,
  parameter logic [7:0]  VERSION  = 8'h01
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_sync,
  input  logic [3:0]  i_cmd,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_sync,
  output logic        o_int,
  output logic [63:0] o_regs,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_we,
  input  logic [15:0] i_tx_data_count,
  input  logic [7:0]  i_tx_frames_count,
  input  logic [7:0]  i_tx_status
);
  import host_ctrl_pkg::*;

  localparam logic [15:0] TX_FULL = 16'(TX_DEPTH);

  state_t      state;
  logic [7:0]  regs [8];
  logic [3:0]  flags;
  logic [3:0]  flag_set;
  logic [3:0]  flag_clr;
  logic [7:0]  prev_frames;
  logic [15:0] prev_count;
  logic        new_cmd;
  logic        seen;
  logic [3:0]  cmd_q;
  logic [7:0]  data_q;
  logic [7:0]  map_data;
  logic        tx_full;

  sync_toggle_det u_det (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (i_en),
    .ready  (state == ST_IDLE),
    .sync   (i_sync),
    .cmd    (i_cmd),
    .data   (i_data),
    .new_cmd(new_cmd),
    .cmd_q  (cmd_q),
    .data_q (data_q),
    .seen   (seen)
  );

  assign tx_full = i_tx_data_count >= TX_FULL;

  always_comb begin
    o_regs = '0;
    for (int k = 0; k < 8; k++) o_regs[8*k +: 8] = regs[k];
  end

  always_comb begin
    map_data = 8'h00;
    if (!data_q[3]) begin
      map_data = regs[data_q[2:0]];
    end else begin
      case (data_q[3:0])
        ADDR_CNT_LO:  map_data = i_tx_data_count[7:0];
        ADDR_CNT_HI:  map_data = i_tx_data_count[15:8];
        ADDR_FRAMES:  map_data = i_tx_frames_count;
        ADDR_STATUS:  map_data = i_tx_status;
        ADDR_FLAGS:   map_data = {4'h0, flags};
        ADDR_INT:     map_data = {7'h00, o_int};
        ADDR_VERSION: map_data = VERSION;
        default:      map_data = 8'h00;
      endcase
    end
  end

  // Event sets are OR'd in after the clear mask so a coincident set survives INT_CLR
  always_comb begin
    flag_set = '0;
    flag_clr = '0;
    flag_set[FLAG_FRAME] = i_tx_frames_count != prev_frames;
    flag_set[FLAG_EMPTY] = (prev_count != 16'd0) && (i_tx_data_count == 16'd0);
    if (state == ST_EXEC) begin
      if (cmd_q == CMD_TX_PUSH && tx_full) flag_set[FLAG_OVF] = 1'b1;
      if (cmd_q[3:2] == 2'b01)             flag_set[FLAG_BADCMD] = 1'b1;
      if (cmd_q == CMD_INT_CLR)            flag_clr = data_q[3:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      for (int k = 0; k < 8; k++) regs[k] <= '0;
      flags       <= '0;
      prev_frames <= '0;
      prev_count  <= '0;
      o_data      <= '0;
      o_sync      <= 1'b0;
      o_int       <= 1'b0;
      o_tx_data   <= '0;
      o_tx_we     <= 1'b0;
    end else begin
      o_tx_we     <= 1'b0;
      prev_frames <= i_tx_frames_count;
      prev_count  <= i_tx_data_count;
      if (!i_en) begin
        state  <= ST_IDLE;
        o_sync <= 1'b0;
        flags  <= '0;
        o_int  <= 1'b0;
      end else begin
        flags <= (flags & ~flag_clr) | flag_set;
        o_int <= |({4'h0, flags} & regs[7]);
        case (state)
          ST_IDLE: if (new_cmd) state <= ST_EXEC;
          ST_EXEC: begin
            if (cmd_q[3]) begin
              regs[cmd_q[2:0]] <= data_q;
            end else begin
              case (cmd_q)
                CMD_READ: o_data <= map_data;
                CMD_TX_PUSH: begin
                  o_tx_data <= data_q;
                  o_tx_we   <= !tx_full;
                end
                CMD_NOP, CMD_INT_CLR: begin
                end
                default: o_data <= ILLEGAL_ACK;
              endcase
            end
            state <= ST_ACK;
          end
          ST_ACK: begin
            o_sync <= seen;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// tb/tb_host_cmd_ctrl.sv - self-checking bench for host_cmd_ctrl (vector table, corner sequences, random vs model)
module tb_host_cmd_ctrl;

`ifdef HOST_SYNC_2FF_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_sync;
  logic [3:0]  i_cmd;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        o_sync;
  logic        o_int;
  logic [63:0] o_regs;
  logic [7:0]  o_tx_data;
  logic        o_tx_we;
  logic [15:0] i_tx_data_count;
  logic [7:0]  i_tx_frames_count;
  logic [7:0]  i_tx_status;

  host_cmd_ctrl dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_en             (i_en),
    .i_sync           (i_sync),
    .i_cmd            (i_cmd),
    .i_data           (i_data),
    .o_data           (o_data),
    .o_sync           (o_sync),
    .o_int            (o_int),
    .o_regs           (o_regs),
    .o_tx_data        (o_tx_data),
    .o_tx_we          (o_tx_we),
    .i_tx_data_count  (i_tx_data_count),
    .i_tx_frames_count(i_tx_frames_count),
    .i_tx_status      (i_tx_status)
  );

  always #5 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         push_cnt = 0;
  logic [7:0] last_tx  = 8'h00;

  always @(negedge i_clk) begin
    if (o_tx_we === 1'b1) begin
      push_cnt <= push_cnt + 1;
      last_tx  <= o_tx_data;
    end
  end

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  data;
    logic [15:0] cnt;
    logic [7:0]  exp_data;
    logic        exp_int;
    int          exp_pushes;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t tv[$];

  logic [7:0]  mregs [8];
  logic [3:0]  mflags;
  logic [7:0]  mdata;
  int          exp_push;
  logic [63:0] snap;
  int          cyc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [3:0] c, input logic [7:0] d);
    i_cmd  = c;
    i_data = d;
    i_sync = ~i_sync;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (o_sync !== i_sync && n < 40) begin
      @(posedge i_clk);
      #1;
      n++;
    end
  endtask

  task automatic do_cmd(input logic [3:0] c, input logic [7:0] d);
    int n;
    start_cmd(c, d);
    wait_ack(n);
    check("latency", 64'(n), 64'(LAT));
  endtask

  function automatic logic [7:0] model_map(input logic [3:0] a, input logic mi);
    logic [7:0] r;
    if (a < 4'd8) r = mregs[a[2:0]];
    else if (a == 4'd8)  r = i_tx_data_count[7:0];
    else if (a == 4'd9)  r = i_tx_data_count[15:8];
    else if (a == 4'd10) r = i_tx_frames_count;
    else if (a == 4'd11) r = i_tx_status;
    else if (a == 4'd12) r = {4'h0, mflags};
    else if (a == 4'd13) r = {7'h00, mi};
    else if (a == 4'd14) r = 8'h01;
    else r = 8'h00;
    return r;
  endfunction

  function automatic logic [63:0] model_regs();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mregs[k];
    return v;
  endfunction

  initial begin
    i_rst_n = 1'b0; i_en = 1'b1; i_sync = 1'b0; i_cmd = 4'h0; i_data = 8'h00;
    i_tx_data_count = 16'd10; i_tx_frames_count = 8'h00; i_tx_status = 8'h6C;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("rst_o_data", o_data, 8'h00);
    check("rst_o_sync", o_sync, 1'b0);
    check("rst_o_int", o_int, 1'b0);
    check("rst_o_tx_we", o_tx_we, 1'b0);
    check("rst_o_regs", o_regs, 64'h0);
    check("rst_o_tx_data", o_tx_data, 8'h00);

    tv.push_back('{4'hB, 8'h5A, 16'd10,   8'h00, 1'b0, 0, 8'h00});
    tv.push_back('{4'h1, 8'h03, 16'd10,   8'h5A, 1'b0, 0, 8'h00});
    tv.push_back('{4'h2, 8'hC3, 16'd10,   8'h5A, 1'b0, 1, 8'hC3});
    tv.push_back('{4'h2, 8'h77, 16'd1024, 8'h5A, 1'b0, 1, 8'hC3});
    tv.push_back('{4'h1, 8'h0C, 16'd1024, 8'h01, 1'b0, 1, 8'hC3});
    tv.push_back('{4'hF, 8'h02, 16'd1024, 8'h01, 1'b0, 1, 8'hC3});
    tv.push_back('{4'h5, 8'h00, 16'd1024, 8'hEE, 1'b1, 1, 8'hC3});
    tv.push_back('{4'h1, 8'h0C, 16'd1024, 8'h03, 1'b1, 1, 8'hC3});
    tv.push_back('{4'h1, 8'h0D, 16'd1024, 8'h01, 1'b1, 1, 8'hC3});
    tv.push_back('{4'h3, 8'h02, 16'd1024, 8'h01, 1'b0, 1, 8'hC3});
    tv.push_back('{4'h1, 8'h0C, 16'd1023, 8'h01, 1'b0, 1, 8'hC3});
    tv.push_back('{4'h2, 8'h9D, 16'd1023, 8'h01, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h08, 16'h0305, 8'h05, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h09, 16'h0305, 8'h03, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h3, 8'h0F, 16'h0305, 8'h03, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h0C, 16'h0305, 8'h00, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h7, 8'h11, 16'h0305, 8'hEE, 1'b1, 2, 8'h9D});
    tv.push_back('{4'h3, 8'h02, 16'h0305, 8'hEE, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h0E, 16'h0305, 8'h01, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h0F, 16'h0305, 8'h00, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h0, 8'hAA, 16'h0305, 8'h00, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h0B, 16'h0305, 8'h6C, 1'b0, 2, 8'h9D});
    tv.push_back('{4'h1, 8'h0A, 16'h0305, 8'h00, 1'b0, 2, 8'h9D});

    for (int i = 0; i < tv.size(); i++) begin
      i_tx_data_count = tv[i].cnt;
      do_cmd(tv[i].cmd, tv[i].data);
      check($sformatf("vec%0d_o_data", i), o_data, tv[i].exp_data);
      check($sformatf("vec%0d_o_int", i), o_int, tv[i].exp_int);
      check($sformatf("vec%0d_pushes", i), 64'(push_cnt), 64'(tv[i].exp_pushes));
      check($sformatf("vec%0d_tx_data", i), last_tx, tv[i].exp_tx);
    end
    check("reg3_after_write", o_regs[31:24], 8'h5A);
    check("reg7_mask", o_regs[63:56], 8'h02);

    // FRAME flag, then a FRAME set landing on the same cycle as INT_CLR of that bit
    do_cmd(4'hF, 8'h04);
    i_tx_frames_count = 8'd4;
    repeat (3) @(posedge i_clk); #1;
    do_cmd(4'h3, 8'h0F);
    check("frame_int_idle", o_int, 1'b0);
    i_tx_frames_count = 8'd5;
    repeat (2) @(posedge i_clk); #1;
    check("frame_int", o_int, 1'b1);
    start_cmd(4'h3, 8'h04);
    repeat (LAT - 2) @(posedge i_clk); #1;
    i_tx_frames_count = 8'd6;
    wait_ack(cyc);
    check("clr_ack", o_sync, i_sync);
    do_cmd(4'h1, 8'h0C);
    check("set_beats_clr", o_data, 8'h04);
    check("set_beats_clr_int", o_int, 1'b1);

    // Two toggles one cycle apart
    start_cmd(4'h9, 8'hA1);
    @(posedge i_clk); #1;
    start_cmd(4'hA, 8'hB2);
    repeat (15) @(posedge i_clk); #1;
    check("pair_reg1", o_regs[15:8], 8'hA1);
    check("pair_reg2", o_regs[23:16], 8'hB2);
    check("pair_sync", o_sync, i_sync);

    // Enable dropped while the write is in EXEC
    snap = o_regs;
    start_cmd(4'hC, 8'h99);
    repeat (LAT - 2) @(posedge i_clk); #1;
    i_en = 1'b0;
    repeat (2) @(posedge i_clk); #1;
    check("en_low_sync", o_sync, 1'b0);
    check("en_low_int", o_int, 1'b0);
    check("en_low_regs", o_regs, snap);
    i_sync = 1'b0;
    repeat (4) @(posedge i_clk); #1;
    i_en = 1'b1;
    repeat (2) @(posedge i_clk); #1;
    do_cmd(4'h1, 8'h0C);
    check("en_flags_cleared", o_data, 8'h00);
    do_cmd(4'h1, 8'h04);
    check("en_reg4_untouched", o_data, 8'h00);
    check("en_regs_kept", o_regs, snap);

    // Reset asserted while a push is in EXEC
    i_tx_data_count = 16'd10;
    start_cmd(4'h2, 8'h5E);
    repeat (LAT - 2) @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_sync = 1'b0;
    i_tx_frames_count = 8'h00;
    repeat (3) @(posedge i_clk); #1;
    check("rst_mid_no_push", 64'(push_cnt), 64'd2);
    check("rst_mid_regs", o_regs, 64'h0);
    check("rst_mid_sync", o_sync, 1'b0);
    check("rst_mid_tx_data", o_tx_data, 8'h00);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk); #1;
    check("rst_mid_after_push", 64'(push_cnt), 64'd2);

    // Randomized commands against a transaction-level model
    for (int k = 0; k < 8; k++) mregs[k] = 8'h00;
    mflags = 4'h0;
    mdata = 8'h00;
    exp_push = 2;
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [3:0] c;
      logic [7:0] d;
      logic mi;
      logic pushed;
      kind = $urandom_range(0, 5);
      d = 8'($urandom);
      case (kind)
        0: c = 4'h0;
        1: c = 4'h1;
        2: c = 4'h2;
        3: c = 4'h3;
        4: c = {1'b1, 3'($urandom_range(0, 7))};
        default: c = 4'($urandom_range(4, 7));
      endcase
      i_tx_data_count = 16'($urandom_range(1015, 1035));
      i_tx_status = 8'($urandom);
      mi = |({4'h0, mflags} & mregs[7]);
      pushed = 1'b0;
      if (c[3]) mregs[c[2:0]] = d;
      else if (c == 4'h1) mdata = model_map(d[3:0], mi);
      else if (c == 4'h2) begin
        if (i_tx_data_count < 16'd1024) begin
          exp_push++;
          pushed = 1'b1;
        end else mflags[0] = 1'b1;
      end
      else if (c == 4'h3) mflags = mflags & ~d[3:0];
      else if (c != 4'h0) begin
        mflags[1] = 1'b1;
        mdata = 8'hEE;
      end
      do_cmd(c, d);
      check($sformatf("rnd%0d_o_data", n), o_data, mdata);
      check($sformatf("rnd%0d_o_regs", n), o_regs, model_regs());
      check($sformatf("rnd%0d_o_int", n), o_int, |({4'h0, mflags} & mregs[7]));
      check($sformatf("rnd%0d_pushes", n), 64'(push_cnt), 64'(exp_push));
      if (pushed) check($sformatf("rnd%0d_tx_data", n), last_tx, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/host_cmd_ctrl.md
# host_cmd_ctrl

Command sequencer between the 8-bit toggle-handshake host bus and the CPLD datapath. It decodes 4-bit host commands, owns the 8-entry writable register bank, and pushes host bytes into the transmitter's write port. It exposes transmitter counters and status through a 16-entry read map, and raises a maskable interrupt. It sits between top-level host pins and the transmitter instance.

## Interface
- TX_DEPTH, 1024: transmitter capacity in bytes; push refused when i_tx_data_count >= TX_DEPTH
- VERSION, 8'h01: constant returned at read address 14
- i_clk  in  1  single clock; all logic on posedge
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  block enable; low = synchronous handshake clear
- i_sync  in  1  host toggle strobe; each level change = new command
- i_cmd  in  4  command code, stable while i_sync toggles
- i_data  in  8  command operand
- o_data  out  8  read result / ack byte
- o_sync  out  1  acknowledge toggle; equals i_sync once command completes
- o_int  out  1  registered interrupt, active high
- o_regs  out  64  writable registers, reg k on bits [8k+7:8k]
- o_tx_data  out  8  byte to transmitter
- o_tx_we  out  1  one-cycle push strobe
- i_tx_data_count  in  16  transmitter fill level
- i_tx_frames_count  in  8  transmitter frames sent
- i_tx_status  in  8  transmitter status

## Operation
- Commands: 0000 NOP (o_data unchanged); 0001 READ (o_data <= map[i_data[3:0]]); 0010 TX_PUSH (o_tx_data <= i_data, o_tx_we pulse if not full, else set flag OVF); 0011 INT_CLR (flags &= ~i_data, W1C); 1xxx WRITE (reg[xxx] <= i_data); 0100-0111 illegal (set flag BADCMD, o_data <= 8'hEE).
- Read map: 0-7 reg[0..7]; 8 tx_data_count[7:0]; 9 tx_data_count[15:8]; 10 tx_frames_count; 11 tx_status; 12 flags; 13 o_int in bit0, other bits 0; 14 VERSION; 15 8'h00.
- reg[7] is INT_MASK. o_int <= |(flags & reg[7]) each cycle.
- Flags: bit0 OVF, bit1 BADCMD, bit2 FRAME (i_tx_frames_count differs from its previous-cycle value), bit3 EMPTY (i_tx_data_count goes from nonzero to zero); bits 7:4 read 0. On the same cycle, a set beats an INT_CLR.
- FSM: IDLE (sync_s != seen -> capture cmd/data, seen <= sync_s, go to EXEC); EXEC (perform the command, go to ACK); ACK (o_sync <= seen, go to IDLE). Toggles arriving outside IDLE are picked up on return to IDLE; none are lost, because `seen` is compared by level.
- i_en low: state IDLE, seen 0, o_sync 0, o_tx_we 0, flags 0, o_int 0. Registers and o_data are retained.
- Reset: all registers 0, o_data 0, o_sync 0, o_int 0, o_tx_we 0, o_tx_data 0, state IDLE.

## Timing
- Without the synchronizer: i_sync toggle sampled at edge N; EXEC at N+1 (o_tx_we high, reg/o_data updated at end of N+1); o_sync toggles at edge N+2, visible after N+2. Three-cycle turnaround.
- The synchronizer adds 2 cycles to every stage above. i_cmd/i_data are captured from the same delayed sample alignment. The host holds them until o_sync matches.
- o_tx_we is high for exactly one cycle per accepted push and is never asserted on a refused push.
- Flag sets and o_int take 1 cycle from the triggering input.
- Reset asserted mid-command: the command is aborted, and no o_tx_we or register write occurs after the reset edge.

## Configuration
- HOST_SYNC_2FF_EN defined: i_sync, i_cmd and i_data pass through two flops before the FSM (asynchronous host). Latency is +2 cycles.
- Undefined: inputs are used directly, because the host is synchronous to i_clk.

## Structure
- Package host_ctrl_pkg holds: command codes, FSM state encoding, read-map address constants, flag bit indices, ILLEGAL_ACK = 8'hEE.
- One sub-module, sync_toggle_det. It contains the optional 2FF stage plus the `seen` compare, and outputs a new-command pulse with captured cmd/data.

## Test plan
- Reset, then WRITE 1011 data 8'h5A, then READ addr 3 -> o_regs[31:24]=8'h5A, o_data=8'h5A, o_sync follows i_sync within 3 cycles (5 with macro).
- TX_PUSH 8'hC3 with data_count=10 -> one o_tx_we pulse with o_tx_data=8'hC3. With data_count=1024 -> no pulse, flags=8'h01.
- reg[7]=8'h02, illegal cmd 0101 -> o_data=8'hEE, o_int=1. INT_CLR 8'h02 -> o_int=0 next cycle.
- frames_count 4->5 with mask 8'h04 -> flags bit2 set, o_int=1. Simultaneous INT_CLR 8'h04 and a new increment -> bit2 stays 1.
- Two i_sync toggles 1 cycle apart -> both executed in order, final o_sync=i_sync.
- i_en low mid-EXEC -> o_sync=0, flags=0, o_regs unchanged. Re-enable with i_sync=0, then toggle -> normal operation.
